// File: rtl/fetch_align_queue.sv
// Fetch aligner and instruction queue: drops slots before the PC offset, truncates after
// a branch plus its delay slot, and buffers survivors for up to ISSUE_WIDTH pops per cycle.
module fetch_align_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSN_WIDTH    = 99,
  parameter int FETCH_WIDTH   = 4,
  parameter int ISSUE_WIDTH   = 2,
  parameter int DEPTH         = 8,
  parameter int BRANCH_BIT    = 9
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Reset,
  input  logic                                 i_Flush,
  input  logic                                 i_Stall,
  input  logic                                 i_Fetch_Valid,
  output logic                                 o_Fetch_Ready,
  input  logic [ADDRESS_WIDTH-1:0]             i_PC,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0]    i_Insns,
  output logic [ISSUE_WIDTH-1:0]               o_Valid,
  output logic [ISSUE_WIDTH*INSN_WIDTH-1:0]    o_Insns,
  output logic [ISSUE_WIDTH*ADDRESS_WIDTH-1:0] o_PCs,
  output logic                                 o_Branch_Trunc,
  output logic [$clog2(DEPTH):0]               o_Count
);

  localparam int OW = $clog2(FETCH_WIDTH);
  localparam int NW = OW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INSN_WIDTH-1:0]    mem_insn [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_pc   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          delay_pending_q, delay_pending_d;
  logic          trunc_q, trunc_d;

  logic [INSN_WIDTH-1:0]    slot_insn [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]   branch_flag;
  logic [OW-1:0]            off;
  logic [OW-1:0]            last_slot;
  logic [NW-1:0]            n_push;
  logic                     trunc_hit;
  logic                     dp_set;
  logic                     found;
  logic                     accept;
  logic [CW-1:0]            free_cnt;
  logic [CW-1:0]            n_pop;

  logic [FETCH_WIDTH-1:0]   wr_en;
  logic [PW-1:0]            wr_addr [FETCH_WIDTH];
  logic [INSN_WIDTH-1:0]    wr_insn [FETCH_WIDTH];
  logic [ADDRESS_WIDTH-1:0] wr_pc   [FETCH_WIDTH];

  assign off = i_PC[OW+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
      assign slot_insn[gi]   = i_Insns[gi*INSN_WIDTH +: INSN_WIDTH];
      assign branch_flag[gi] = slot_insn[gi][BRANCH_BIT];
    end
  endgenerate

  // Kept slots are always the contiguous run off..last_slot.
  always_comb begin
    last_slot = OW'(FETCH_WIDTH - 1);
    trunc_hit = 1'b0;
    dp_set    = 1'b0;
    found     = 1'b0;
    if (delay_pending_q) begin
      last_slot = off;
      trunc_hit = (off != OW'(FETCH_WIDTH - 1));
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (!found && (k >= int'(off)) && branch_flag[k]) begin
          found = 1'b1;
          if (k < FETCH_WIDTH - 1) begin
            last_slot = OW'(k + 1);
            trunc_hit = (k + 1 < FETCH_WIDTH - 1);
          end else begin
            dp_set = 1'b1;
          end
        end
      end
    end
    n_push = NW'(last_slot) - NW'(off) + NW'(1);
  end

  assign free_cnt      = CW'(DEPTH) - count_q;
  assign o_Fetch_Ready = !i_Flush && (free_cnt >= CW'(FETCH_WIDTH));
  assign accept        = i_Fetch_Valid && o_Fetch_Ready;

  always_comb begin
    n_pop = '0;
    if (!i_Stall && !i_Flush) begin
      n_pop = (count_q >= CW'(ISSUE_WIDTH)) ? CW'(ISSUE_WIDTH) : count_q;
    end
  end

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    delay_pending_d = delay_pending_q;
    trunc_d         = 1'b0;
    if (i_Flush) begin
      head_d          = '0;
      tail_d          = '0;
      count_d         = '0;
      delay_pending_d = 1'b0;
    end else begin
      head_d  = head_q + PW'(n_pop);
      count_d = count_q + (accept ? CW'(n_push) : CW'(0)) - n_pop;
      if (accept) begin
        tail_d          = tail_q + PW'(n_push);
        delay_pending_d = dp_set;
        trunc_d         = trunc_hit;
      end
    end
  end

  // Compacted write lane gi carries slot off+gi; lanes at or beyond n_push are idle.
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
      logic [OW-1:0] src;
      assign src         = off + OW'(gi);
      assign wr_en[gi]   = accept && !i_Reset && (NW'(gi) < n_push);
      assign wr_addr[gi] = tail_q + PW'(gi);
      assign wr_insn[gi] = slot_insn[src];
      assign wr_pc[gi]   = i_PC + ADDRESS_WIDTH'(4 * gi);
    end
  endgenerate

  always_ff @(posedge i_Clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) begin
        mem_insn[wr_addr[i]] <= wr_insn[i];
        mem_pc[wr_addr[i]]   <= wr_pc[i];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      delay_pending_q <= 1'b0;
      trunc_q         <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      delay_pending_q <= delay_pending_d;
      trunc_q         <= trunc_d;
    end
  end

  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_out
      logic [PW-1:0] rd_idx;
      assign rd_idx      = head_q + PW'(gi);
      assign o_Valid[gi] = (count_q > CW'(gi));
      assign o_Insns[gi*INSN_WIDTH +: INSN_WIDTH] =
        o_Valid[gi] ? mem_insn[rd_idx] : '0;
      assign o_PCs[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH] =
        o_Valid[gi] ? mem_pc[rd_idx] : '0;
    end
  endgenerate

  assign o_Branch_Trunc = trunc_q;
  assign o_Count        = count_q;

endmodule

// File: tb/tb_fetch_align_queue.sv
// Bench for fetch_align_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_fetch_align_queue;
  localparam int AW     = 32;
  localparam int INSN_W = 99;
  localparam int FW     = 4;
  localparam int ISW    = 2;
  localparam int DEPTH  = 8;
  localparam int BB     = 9;

  logic clk = 1'b0;
  logic rst, flush, stall, fv;
  logic [AW-1:0] pc;
  logic [FW*INSN_W-1:0] insns;
  logic fetch_ready;
  logic [ISW-1:0] o_valid;
  logic [ISW*INSN_W-1:0] o_insns;
  logic [ISW*AW-1:0] o_pcs;
  logic o_trunc;
  logic [$clog2(DEPTH):0] o_count;

  logic [INSN_W-1:0] mq_insn[$];
  logic [AW-1:0] mq_pc[$];
  bit m_dp, m_trunc;
  int cmp_cnt = 0;
  int err_cnt = 0;

  fetch_align_queue #(
    .ADDRESS_WIDTH(AW), .INSN_WIDTH(INSN_W), .FETCH_WIDTH(FW),
    .ISSUE_WIDTH(ISW), .DEPTH(DEPTH), .BRANCH_BIT(BB)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Flush(flush), .i_Stall(stall),
    .i_Fetch_Valid(fv), .o_Fetch_Ready(fetch_ready), .i_PC(pc), .i_Insns(insns),
    .o_Valid(o_valid), .o_Insns(o_insns), .o_PCs(o_pcs),
    .o_Branch_Trunc(o_trunc), .o_Count(o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: a plain FIFO of kept instructions, filled by the alignment rules.
  function automatic void model_update();
    int off, s, last, npop;
    bit ready;
    if (rst || flush) begin
      mq_insn.delete(); mq_pc.delete(); m_dp = 0; m_trunc = 0;
      return;
    end
    ready = (DEPTH - mq_insn.size()) >= FW;
    npop = stall ? 0 : ((mq_insn.size() < ISW) ? mq_insn.size() : ISW);
    for (int i = 0; i < npop; i++) begin
      void'(mq_insn.pop_front());
      void'(mq_pc.pop_front());
    end
    m_trunc = 0;
    if (fv && ready) begin
      off = int'((pc >> 2) % FW);
      last = FW - 1;
      if (m_dp) begin
        last = off; m_dp = 0; m_trunc = (off < FW - 1);
      end else begin
        s = -1;
        for (int k = off; k < FW; k++) if (s < 0 && insns[k*INSN_W + BB]) s = k;
        if (s >= 0 && s < FW - 1) begin
          last = s + 1; m_trunc = (s + 1 < FW - 1);
        end else if (s == FW - 1) begin
          last = s; m_dp = 1;
        end
      end
      for (int k = off; k <= last; k++) begin
        mq_insn.push_back(insns[k*INSN_W +: INSN_W]);
        mq_pc.push_back(pc + AW'(4 * (k - off)));
      end
      $display("accept pc=%h kept=%0d trunc=%0d dp=%0d", pc, last - off + 1, m_trunc, m_dp);
    end
  endfunction

  function automatic logic [INSN_W-1:0] rand_insn(input bit br);
    logic [127:0] r;
    logic [INSN_W-1:0] x;
    r = {$urandom, $urandom, $urandom, $urandom};
    x = r[INSN_W-1:0];
    x[BB] = br;
    return x;
  endfunction

  function automatic logic [FW*INSN_W-1:0] make_group(input logic [FW-1:0] br);
    logic [FW*INSN_W-1:0] g;
    for (int k = 0; k < FW; k++) g[k*INSN_W +: INSN_W] = rand_insn(br[k]);
    return g;
  endfunction

  task automatic drive(input bit r, input bit f, input bit s, input bit v,
                       input logic [AW-1:0] p, input logic [FW*INSN_W-1:0] g);
    rst = r; flush = f; stall = s; fv = v; pc = p; insns = g;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 32'h100, make_group(4'b0000));
    step(); #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", o_count); end
    cmp_cnt++; if (o_valid !== 2'b00) begin err_cnt++; $display("FAIL reset_valid: got %b want 00", o_valid); end
    cmp_cnt++; if (o_trunc !== 1'b0) begin err_cnt++; $display("FAIL reset_trunc: got %b want 0", o_trunc); end
    step();
    drive(0, 0, 0, 0, '0, '0); #1;
    cmp_cnt++; if (fetch_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b want 1", fetch_ready); end
  endtask

  task automatic test_no_branch();
    logic [FW*INSN_W-1:0] g;
    g = make_group(4'b0000);
    drive(0, 0, 0, 1, 32'h100, g);
    step();
    drive(0, 0, 0, 0, '0, '0); #1;
    cmp_cnt++; if (o_valid !== 2'b11) begin err_cnt++; $display("FAIL nobr_valid: got %b want 11", o_valid); end
    cmp_cnt++; if (o_pcs !== {32'h104, 32'h100}) begin err_cnt++; $display("FAIL nobr_pcs0: got %h want 0000010400000100", o_pcs); end
    cmp_cnt++; if (o_insns !== g[2*INSN_W-1:0]) begin err_cnt++; $display("FAIL nobr_insns0: got %h want %h", o_insns, g[2*INSN_W-1:0]); end
    cmp_cnt++; if (o_count !== 4) begin err_cnt++; $display("FAIL nobr_count0: got %0d want 4", o_count); end
    step(); #1;
    cmp_cnt++; if (o_pcs !== {32'h10C, 32'h108}) begin err_cnt++; $display("FAIL nobr_pcs1: got %h want 0000010c00000108", o_pcs); end
    cmp_cnt++; if (o_insns !== g[4*INSN_W-1:2*INSN_W]) begin err_cnt++; $display("FAIL nobr_insns1: got %h want %h", o_insns, g[4*INSN_W-1:2*INSN_W]); end
    step(); #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL nobr_drained: got %0d want 0", o_count); end
    cmp_cnt++; if (o_valid !== 2'b00) begin err_cnt++; $display("FAIL nobr_empty_valid: got %b want 00", o_valid); end
  endtask

  task automatic test_offset();
    logic [FW*INSN_W-1:0] g;
    g = make_group(4'b0000);
    drive(0, 0, 1, 1, 32'h108, g);
    step();
    drive(0, 0, 1, 0, '0, '0); #1;
    cmp_cnt++; if (o_count !== 2) begin err_cnt++; $display("FAIL off_count: got %0d want 2", o_count); end
    cmp_cnt++; if (o_pcs !== {32'h10C, 32'h108}) begin err_cnt++; $display("FAIL off_pcs: got %h want 0000010c00000108", o_pcs); end
    cmp_cnt++; if (o_insns !== g[4*INSN_W-1:2*INSN_W]) begin err_cnt++; $display("FAIL off_insns: got %h want %h", o_insns, g[4*INSN_W-1:2*INSN_W]); end
    drive(0, 0, 0, 0, '0, '0);
    step(); #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL off_drained: got %0d want 0", o_count); end
  endtask

  task automatic test_branch_trunc();
    drive(0, 0, 1, 1, 32'h100, make_group(4'b0010));
    step();
    drive(0, 0, 1, 0, '0, '0); #1;
    cmp_cnt++; if (o_count !== 3) begin err_cnt++; $display("FAIL br_count: got %0d want 3", o_count); end
    cmp_cnt++; if (o_trunc !== 1'b1) begin err_cnt++; $display("FAIL br_trunc_hi: got %b want 1", o_trunc); end
    step(); #1;
    cmp_cnt++; if (o_trunc !== 1'b0) begin err_cnt++; $display("FAIL br_trunc_lo: got %b want 0", o_trunc); end
    drive(0, 0, 0, 0, '0, '0); #1;
    cmp_cnt++; if (o_pcs !== {32'h104, 32'h100}) begin err_cnt++; $display("FAIL br_pcs0: got %h want 0000010400000100", o_pcs); end
    step(); #1;
    cmp_cnt++; if (o_valid !== 2'b01) begin err_cnt++; $display("FAIL br_valid1: got %b want 01", o_valid); end
    cmp_cnt++; if (o_pcs !== {32'h0, 32'h108}) begin err_cnt++; $display("FAIL br_pcs1: got %h want 0000000000000108", o_pcs); end
    step(); #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL br_drained: got %0d want 0", o_count); end
  endtask

  task automatic test_delay_slot();
    drive(0, 0, 1, 1, 32'h100, make_group(4'b1000));
    step(); #1;
    cmp_cnt++; if (o_count !== 4) begin err_cnt++; $display("FAIL ds_count0: got %0d want 4", o_count); end
    cmp_cnt++; if (o_trunc !== 1'b0) begin err_cnt++; $display("FAIL ds_trunc0: got %b want 0", o_trunc); end
    // Slot 0 carries a branch flag that must be ignored as a delay slot.
    drive(0, 0, 1, 1, 32'h200, make_group(4'b0001));
    step();
    drive(0, 0, 1, 0, '0, '0); #1;
    cmp_cnt++; if (o_count !== 5) begin err_cnt++; $display("FAIL ds_count1: got %0d want 5", o_count); end
    cmp_cnt++; if (o_trunc !== 1'b1) begin err_cnt++; $display("FAIL ds_trunc1: got %b want 1", o_trunc); end
    drive(0, 0, 0, 0, '0, '0); #1;
    cmp_cnt++; if (o_pcs !== {32'h104, 32'h100}) begin err_cnt++; $display("FAIL ds_pcs0: got %h want 0000010400000100", o_pcs); end
    step(); #1;
    cmp_cnt++; if (o_pcs !== {32'h10C, 32'h108}) begin err_cnt++; $display("FAIL ds_pcs1: got %h want 0000010c00000108", o_pcs); end
    step(); #1;
    cmp_cnt++; if (o_pcs !== {32'h0, 32'h200}) begin err_cnt++; $display("FAIL ds_pcs2: got %h want 0000000000000200", o_pcs); end
    step(); #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL ds_drained: got %0d want 0", o_count); end
  endtask

  task automatic test_full_stall();
    drive(0, 0, 1, 1, 32'h100, make_group(4'b0000));
    step();
    drive(0, 0, 1, 1, 32'h110, make_group(4'b0000));
    step(); #1;
    cmp_cnt++; if (o_count !== 8) begin err_cnt++; $display("FAIL full_count: got %0d want 8", o_count); end
    cmp_cnt++; if (fetch_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready: got %b want 0", fetch_ready); end
    drive(0, 0, 0, 1, 32'h120, make_group(4'b0000));
    step(); #1;
    cmp_cnt++; if (o_count !== 6) begin err_cnt++; $display("FAIL full_pop_count: got %0d want 6", o_count); end
    drive(0, 0, 1, 1, 32'h120, insns); #1;
    cmp_cnt++; if (fetch_ready !== 1'b0) begin err_cnt++; $display("FAIL full_pop_ready: got %b want 0", fetch_ready); end
    drive(0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) step();
    #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL full_drained: got %0d want 0", o_count); end
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 1, 32'h108, make_group(4'b0000));
    step();
    drive(0, 0, 1, 1, 32'h104, make_group(4'b1000));
    step(); #1;
    cmp_cnt++; if (o_count !== 5) begin err_cnt++; $display("FAIL fl_pre_count: got %0d want 5", o_count); end
    drive(0, 1, 1, 1, 32'h100, make_group(4'b0000)); #1;
    cmp_cnt++; if (fetch_ready !== 1'b0) begin err_cnt++; $display("FAIL fl_ready: got %b want 0", fetch_ready); end
    step();
    drive(0, 0, 1, 0, '0, '0); #1;
    cmp_cnt++; if (o_count !== 0) begin err_cnt++; $display("FAIL fl_count: got %0d want 0", o_count); end
    cmp_cnt++; if (o_valid !== 2'b00) begin err_cnt++; $display("FAIL fl_valid: got %b want 00", o_valid); end
    drive(0, 0, 1, 1, 32'h100, make_group(4'b0000));
    step();
    drive(0, 0, 1, 0, '0, '0); #1;
    cmp_cnt++; if (o_count !== 4) begin err_cnt++; $display("FAIL fl_fresh_count: got %0d want 4", o_count); end
    cmp_cnt++; if (o_trunc !== 1'b0) begin err_cnt++; $display("FAIL fl_fresh_trunc: got %b want 0", o_trunc); end
    drive(0, 0, 0, 0, '0, '0);
    step(); step();
  endtask

  task automatic test_random();
    logic [ISW-1:0] e_valid;
    logic [ISW*INSN_W-1:0] e_insns;
    logic [ISW*AW-1:0] e_pcs;
    logic e_ready;
    logic [FW-1:0] br;
    logic [AW-1:0] p;
    drive(1, 0, 0, 0, '0, '0);
    step();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < FW; k++) br[k] = ($urandom_range(0, 99) < 20);
      p = {$urandom} & ~32'h3;
      if ($urandom_range(0, 9) == 0) p = 32'hFFFF_FFF0 | (p & 32'hC);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 75), p, make_group(br));
      #1;
      e_ready = !flush && ((DEPTH - mq_insn.size()) >= FW);
      e_valid = '0; e_insns = '0; e_pcs = '0;
      for (int k = 0; k < ISW; k++) begin
        if (k < mq_insn.size()) begin
          e_valid[k] = 1'b1;
          e_insns[k*INSN_W +: INSN_W] = mq_insn[k];
          e_pcs[k*AW +: AW] = mq_pc[k];
        end
      end
      cmp_cnt++; if (fetch_ready !== e_ready) begin err_cnt++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, fetch_ready, e_ready); end
      cmp_cnt++; if (o_count !== mq_insn.size()) begin err_cnt++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, o_count, mq_insn.size()); end
      cmp_cnt++; if (o_valid !== e_valid) begin err_cnt++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, o_valid, e_valid); end
      cmp_cnt++; if (o_trunc !== m_trunc) begin err_cnt++; $display("FAIL rnd_trunc c=%0d: got %b want %b", c, o_trunc, m_trunc); end
      cmp_cnt++; if (o_pcs !== e_pcs) begin err_cnt++; $display("FAIL rnd_pcs c=%0d: got %h want %h", c, o_pcs, e_pcs); end
      cmp_cnt++; if (o_insns !== e_insns) begin err_cnt++; $display("FAIL rnd_insns c=%0d: got %h want %h", c, o_insns, e_insns); end
      step();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, '0, '0);
    @(negedge clk);
    test_reset();
    test_no_branch();
    test_offset();
    test_branch_trunc();
    test_delay_slot();
    test_full_stall();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
